// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB types, FU indices and default widths
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 6
`endif

package cdb_arbiter_pkg;

    localparam int XLEN_W    = `XLEN;
    localparam int ROB_TAG_W = `ROB_SIZE;

    localparam int NUM_FU  = 4;
    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_LSU  = 2;
    localparam int FU_BRU  = 3;

    // One broadcast slot as seen by the reservation stations and the ROB.
    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN_W-1:0]    value;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// rtl/cdb_arbiter_rr_priority_pick.sv - rotate/find-first/rotate-back round-robin picker
module cdb_arbiter_rr_priority_pick #(
    parameter int N     = 4,
    parameter int SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [SRC_W-1:0] idx_o,
    output logic             any_o
);

    localparam logic [SRC_W:0] N_W = (SRC_W+1)'(N);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [SRC_W-1:0] first;
    logic [SRC_W:0]   sum;

    always_comb begin
        doubled = {req_i, req_i};
        rotated = doubled[ptr_i +: N];
        any_o   = 1'b0;
        first   = '0;
        // Descending scan so the lowest set bit (closest to the pointer) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                any_o = 1'b1;
                first = SRC_W'(i);
            end
        end
        sum = {1'b0, first} + {1'b0, ptr_i};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx_o   = sum[SRC_W-1:0];
        grant_o = '0;
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with registered broadcast; CDB_ARB_STATS_EN adds grant counters
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU,
    parameter int DATA_W  = XLEN_W,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_value_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      cdb_valid_o,
    output logic [TAG_W-1:0]          cdb_tag_o,
    output logic [DATA_W-1:0]         cdb_value_o,
    output logic [SRC_W-1:0]          cdb_src_o
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt_o
`endif
);

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_any;

    logic [SRC_W-1:0]  ptr_q,   ptr_d;
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [SRC_W-1:0]  src_q,   src_d;

    // Masking the request vector keeps ready independent of the output register.
    assign pick_req = (rst || stall_i || flush_i) ? '0 : req_valid_i;

    cdb_arbiter_rr_priority_pick #(
        .N     (NUM_REQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req_i   (pick_req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign req_ready_o = grant;

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = grant_any;
        tag_d   = tag_q;
        value_d = value_q;
        src_d   = src_q;
        if (grant_any) begin
            tag_d   = req_tag_i[grant_idx*TAG_W +: TAG_W];
            value_d = req_value_i[grant_idx*DATA_W +: DATA_W];
            src_d   = grant_idx;
            ptr_d   = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            value_q <= '0;
            src_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            value_q <= value_d;
            src_q   <= src_d;
        end
    end

    assign cdb_valid_o = valid_q;
    assign cdb_tag_o   = tag_q;
    assign cdb_value_o = value_q;
    assign cdb_src_o   = src_q;

`ifdef CDB_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (grant[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt_o[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed plus randomized bench for cdb_arbiter against a scan-order model
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = XLEN_W;
    localparam int TW = ROB_TAG_W;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall_i;
    logic             flush_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR*TW-1:0] req_tag_i;
    logic [NR*DW-1:0] req_value_i;
    logic [NR-1:0]    req_ready_o;
    logic             cdb_valid_o;
    logic [TW-1:0]    cdb_tag_o;
    logic [DW-1:0]    cdb_value_o;
    logic [SW-1:0]    cdb_src_o;
`ifdef CDB_ARB_STATS_EN
    logic [NR*16-1:0] grant_cnt_o;
`endif

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_tag_i   (req_tag_i),
        .req_value_i (req_value_i),
        .req_ready_o (req_ready_o),
        .cdb_valid_o (cdb_valid_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_value_o (cdb_value_o),
        .cdb_src_o   (cdb_src_o)
`ifdef CDB_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Requester side: pending flags with held tag/value; keep re-raises after a grant.
    logic          u_valid [NR];
    logic          u_keep  [NR];
    logic [TW-1:0] u_tag   [NR];
    logic [DW-1:0] u_value [NR];

    // Reference model state.
    int            m_ptr;
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_value;
    logic [SW-1:0] m_src;
    int            m_cnt [NR];

    int            n_asrt = 0;
    int            n_fail = 0;
    logic [NR-1:0] last_ready;
    int            grants_seen [$];
    int            valid_run;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid_i[i]            = u_valid[i];
            req_tag_i[i*TW +: TW]     = u_tag[i];
            req_value_i[i*DW +: DW]   = u_value[i];
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < NR; k++) begin
            int u;
            u = (m_ptr + k) % NR;
            if (u_valid[u]) return u;
        end
        return -1;
    endfunction

    // One clock: check at the falling edge, advance the model on the rising edge.
    task automatic tick();
        int            g;
        logic          xfer;
        logic [NR-1:0] exp_ready;
        drive();
        @(negedge clk);
        g         = model_pick();
        xfer      = !rst && !stall_i && !flush_i && (g >= 0);
        exp_ready = xfer ? NR'(1 << g) : '0;
        last_ready = req_ready_o;
        chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
        chk("cdb_valid", 64'(cdb_valid_o), 64'(m_valid));
        chk("cdb_tag",   64'(cdb_tag_o),   64'(m_tag));
        chk("cdb_value", 64'(cdb_value_o), 64'(m_value));
        chk("cdb_src",   64'(cdb_src_o),   64'(m_src));
`ifdef CDB_ARB_STATS_EN
        for (int i = 0; i < NR; i++)
            chk("grant_cnt", 64'(grant_cnt_o[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = '0;
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        end else if (xfer) begin
            m_valid = 1'b1;
            m_tag   = u_tag[g];
            m_value = u_value[g];
            m_src   = SW'(g);
            m_ptr   = (g + 1) % NR;
            if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
            grants_seen.push_back(g);
            if (!u_keep[g]) u_valid[g] = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic clear_units();
        for (int i = 0; i < NR; i++) begin
            u_valid[i] = 1'b0; u_keep[i] = 1'b0; u_tag[i] = '0; u_value[i] = '0;
        end
    endtask

    task automatic set_unit(input int i, input int tag, input int value, input logic keep);
        u_valid[i] = 1'b1;
        u_keep[i]  = keep;
        u_tag[i]   = TW'(tag);
        u_value[i] = DW'(value);
    endtask

    initial begin
        clear_units();
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = '0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        drive();
        @(posedge clk); #1;

        // Reset, then a single request from the load unit.
        tick(); tick();
        rst = 1'b0;
        set_unit(FU_LSU, 10, 256, 1'b0);
        tick();
        chk("single_ready", 64'(last_ready), 64'h4);
        chk("single_valid", 64'(cdb_valid_o), 64'h1);
        chk("single_tag",   64'(cdb_tag_o),   64'd10);
        chk("single_value", 64'(cdb_value_o), 64'd256);
        chk("single_src",   64'(cdb_src_o),   64'd2);
        tick();
        chk("single_drop", 64'(cdb_valid_o), 64'h0);

        // Fairness from a cleared pointer.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NR; i++) set_unit(i, 20 + i, 100 + i, 1'b1);
        grants_seen.delete();
        valid_run = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_order", 64'(last_ready), 64'(1 << (k % NR)));
            if (cdb_valid_o) valid_run++;
        end
        chk("rr_valid_run", 64'(valid_run), 64'd8);

        // Back-pressure: move the pointer to 2, then units 1 and 3 compete.
        clear_units();
        set_unit(FU_ALU1, 5, 7, 1'b0);
        tick();
        set_unit(FU_ALU1, 12, 16, 1'b0);
        set_unit(FU_BRU, 33, 99, 1'b0);
        tick();
        chk("bp_first", 64'(last_ready), 64'h8);
        tick();
        chk("bp_second", 64'(last_ready), 64'h2);
        tick();
        chk("bp_tag",   64'(cdb_tag_o),   64'd12);
        chk("bp_value", 64'(cdb_value_o), 64'd16);
        chk("bp_src",   64'(cdb_src_o),   64'd1);

        // Stall with every unit valid; grants resume from pointer 2.
        for (int i = 0; i < NR; i++) set_unit(i, 40 + i, 200 + i, 1'b1);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_ready", 64'(last_ready), 64'h0);
        end
        chk("stall_valid", 64'(cdb_valid_o), 64'h0);
        stall_i = 1'b0;
        tick();
        chk("stall_resume", 64'(last_ready), 64'h4);

        // Flush the cycle after a transfer from unit 0.
        clear_units();
        tick();
        set_unit(FU_ALU0, 3, 4, 1'b0);
        tick();
        set_unit(FU_ALU0, 6, 8, 1'b0);
        flush_i = 1'b1;
        tick();
        chk("flush_ready", 64'(last_ready), 64'h0);
        chk("flush_drop",  64'(cdb_valid_o), 64'h0);
        flush_i = 1'b0;
        stall_i = 1'b1;
        tick();
        stall_i = 1'b0;
        clear_units();
        tick();

`ifdef CDB_ARB_STATS_EN
        rst = 1'b1; tick(); rst = 1'b0;
        set_unit(FU_ALU0, 1, 2, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("stats_five", 64'(grant_cnt_o[15:0]), 64'd5);
        clear_units();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("stats_clear", 64'(grant_cnt_o[15:0]), 64'd0);
        chk("stats_valid", 64'(cdb_valid_o), 64'h0);
`endif

        // Randomized traffic with stalls, flushes and occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!u_valid[i] && ($urandom_range(0, 1) == 1))
                    set_unit(i, int'($urandom_range(0, (1 << TW) - 1)), int'($urandom), 1'b0);
            end
            stall_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Schedules the single common data bus (CDB) among NUM_REQ functional-unit result ports (ALUs, load unit, branch unit).
- One result is granted per cycle using round-robin priority.
- The granted result is broadcast through a registered output stage onto cdb_valid/cdb_tag/cdb_value, which feed every reservation station and the ROB.
- A functional unit whose request is not granted back-pressures through its ready signal.

Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8).
- DATA_W, `XLEN, result value width.
- TAG_W, `ROB_SIZE, ROB tag width.
- SRC_W, $clog2(NUM_REQ), width of the source index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  pipeline stall; no grants are made while high.
- flush_i  in  1  mispredict flush; drops the pending broadcast.
- req_valid_i  in  NUM_REQ  per-unit result valid.
- req_tag_i  in  NUM_REQ*TAG_W  per-unit ROB tag; unit i occupies slice [i*TAG_W +: TAG_W].
- req_value_i  in  NUM_REQ*DATA_W  per-unit result; unit i occupies slice [i*DATA_W +: DATA_W].
- req_ready_o  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- cdb_valid_o  out  1  broadcast valid, one cycle per result.
- cdb_tag_o  out  TAG_W  broadcast ROB tag.
- cdb_value_o  out  DATA_W  broadcast value.
- cdb_src_o  out  SRC_W  index of the unit that won arbitration.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cdb_valid_o=0, cdb_tag_o=0, cdb_value_o=0, cdb_src_o=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready_o is 0 during the reset cycle.
- Grant is combinational within the cycle:
  - If stall_i=1, flush_i=1, or rst=1, then req_ready_o=0.
  - Otherwise, the first i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ, gets req_ready_o[i]=1. All other bits are 0.
  - At most one bit of req_ready_o is ever set.
- Requester rules:
  - Once req_valid_i[i] is raised, the unit holds it and its tag/value stable until it sees req_ready_o[i]=1 (no retraction).
  - req_ready_o never depends on the current cycle's output register.
- Latency: a transfer at edge N drives cdb_valid_o=1 with the granted tag, value and source index during cycle N+1.
  - cdb_valid_o is 1 for exactly one cycle per transfer.
  - One broadcast per cycle is sustainable; there are no bubbles under continuous requests.
- Pointer update: on a transfer from unit g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- No requests: cdb_valid_o <= 0 next cycle. Tag, value and source hold their last values (don't-care while valid is 0).
- stall_i=1: no transfer, so cdb_valid_o <= 0 next cycle. A broadcast already registered completes its single valid cycle unaffected. rr_ptr holds.
- flush_i=1: no transfer, cdb_valid_o <= 0 next cycle (the in-flight broadcast is not repeated), rr_ptr holds.
- flush_i and stall_i together: the same as flush_i alone.
- rst mid-operation: overrides everything. Any registered broadcast is dropped and the pointer is cleared.
- Starvation bound: a continuously valid requester is granted within NUM_REQ transfer cycles.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- With the macro defined:
  - Adds output port grant_cnt_o (NUM_REQ*16 bits), one 16-bit saturating counter per unit.
  - Counter i increments on each transfer from unit i and saturates at 16'hFFFF.
  - rst clears all counters; flush_i does not.
- Without the macro: the port and the counters are absent. The rest of the behaviour is identical.

Decomposition:
- Shared package (alongside constants.vh): a cdb_bus_t packed struct {valid, tag[TAG_W], value[DATA_W]}, reused by the reservation stations and the ROB.
- The package also holds the NUM_FU constant and the FU index constants (FU_ALU0, FU_ALU1, FU_LSU, FU_BRU).
- Natural sub-module: rr_priority_pick, a combinational rotate / find-first / rotate-back that returns the one-hot grant and its encoded index. The top level holds the pointer, the output register and the stats counters.

Test Plan:
- Reset then single request: rst for 2 cycles, then req_valid_i=4'b0100 with tag 10, value 256 → req_ready_o=4'b0100 that cycle; next cycle cdb_valid_o=1, tag=10, value=256, src=2; following cycle valid=0 and rr_ptr=3.
- Round-robin fairness: all four valid continuously for 8 cycles from rr_ptr=0 → grant order 0,1,2,3,0,1,2,3; cdb_valid_o high for 8 consecutive cycles.
- Back-pressure: units 1 and 3 valid with rr_ptr=2 → unit 3 granted first and unit 1 next; unit 1 holds tag 12, value 16 unchanged until its ready, then broadcasts them.
- Stall: stall_i=1 for 3 cycles with all units valid → req_ready_o=0 and cdb_valid_o=0 after the first stalled cycle; rr_ptr unchanged; grants resume from the same pointer when stall drops.
- Flush: transfer from unit 0 at edge N together with flush_i=1 in cycle N+1 → cdb_valid_o drops at N+2; no grant in cycle N+1.
- Reset mid-stream plus stats (CDB_ARB_STATS_EN defined): 5 grants to unit 0, then rst → grant_cnt_o[0] reads 5 before the reset and 0, with cdb_valid_o=0, after it.
